// File: rtl/pipelined_rca.sv
// Pipelined ripple-carry add/subtract: STAGES segments of WIDTH/STAGES bits, one register bank per segment.
// Latency STAGES cycles; valid/ready with per-stage stall, bubbles collapse toward the output.
module pipelined_rca #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int SEG = WIDTH / STAGES;
  localparam int MSB = WIDTH - 1;
  localparam int LST = STAGES - 1;

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] load;
  logic [WIDTH-1:0]  a_s [STAGES];
  logic [WIDTH-1:0]  b_s [STAGES];
  logic [WIDTH-1:0]  s_s [STAGES];
  logic              c_s [STAGES];

  logic [WIDTH-1:0]  b_eff;
  logic              c_eff;

  // Subtraction as A + ~B + ~cin, so the borrow-in arrives inverted.
  assign b_eff = in_sub ? ~in_b : in_b;
  assign c_eff = in_sub ? ~in_cin : in_cin;

  // A stage may load if it, or any stage after it, is empty, or the output drains.
  always_comb begin
    logic acc;
    acc  = out_ready;
    load = '0;
    for (int k = LST; k >= 0; k--) begin
      acc     = acc | ~vld[k];
      load[k] = acc;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             v_in;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] s_in;
    logic             c_in;
    logic [WIDTH-1:0] s_nxt;
    logic             c_nxt;
    logic             v_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] s_r;
    logic             c_r;

    if (k == 0) begin : g_first
      assign v_in = in_valid;
      assign a_in = in_a;
      assign b_in = b_eff;
      assign s_in = '0;
      assign c_in = c_eff;
    end else begin : g_next
      assign v_in = vld[k-1];
      assign a_in = a_s[k-1];
      assign b_in = b_s[k-1];
      assign s_in = s_s[k-1];
      assign c_in = c_s[k-1];
    end

    // Carry chain confined to this stage's SEG bits.
    always_comb begin
      logic c;
      c     = c_in;
      s_nxt = s_in;
      for (int i = 0; i < SEG; i++) begin
        s_nxt[k*SEG+i] = a_in[k*SEG+i] ^ b_in[k*SEG+i] ^ c;
        c = (a_in[k*SEG+i] & b_in[k*SEG+i]) | (c & (a_in[k*SEG+i] ^ b_in[k*SEG+i]));
      end
      c_nxt = c;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_r <= 1'b0;
        a_r <= '0;
        b_r <= '0;
        s_r <= '0;
        c_r <= 1'b0;
      end else if (load[k]) begin
        v_r <= v_in;
        if (v_in) begin
          a_r <= a_in;
          b_r <= b_in;
          s_r <= s_nxt;
          c_r <= c_nxt;
        end
      end
    end

    assign vld[k] = v_r;
    assign a_s[k] = a_r;
    assign b_s[k] = b_r;
    assign s_s[k] = s_r;
    assign c_s[k] = c_r;
  end

  assign in_ready  = load[0];
  assign out_valid = vld[LST];
  assign out_sum   = s_s[LST];
  assign out_cout  = c_s[LST];
  // b_s holds the conditioned operand, so this is also correct for A-B.
  assign out_ovf   = (a_s[LST][MSB] == b_s[LST][MSB]) && (s_s[LST][MSB] != a_s[LST][MSB]);

endmodule

// File: tb/tb_pipelined_rca.sv
// Bench for pipelined_rca: directed vector table, stall/bubble/reset sequences, random valid/ready run,
// plus single-op latency checks on (8,1), (12,3) and (4,4) instances.
module tb_pipelined_rca;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, in_cin, in_sub;
  logic [15:0] in_a, in_b;
  logic        out_valid, out_ready, out_cout, out_ovf;
  logic [15:0] out_sum;

  pipelined_rca #(.WIDTH(16), .STAGES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_cout(out_cout), .out_ovf(out_ovf)
  );

  logic       aux_ready = 1'b1;
  logic       x1_valid, x1_rdy, x1_ov, x1_co, x1_of, x1_sub;
  logic [7:0] x1_a, x1_b, x1_s;
  logic       x3_valid, x3_rdy, x3_ov, x3_co, x3_of, x3_sub;
  logic [11:0] x3_a, x3_b, x3_s;
  logic       x4_valid, x4_rdy, x4_ov, x4_co, x4_of, x4_sub;
  logic [3:0] x4_a, x4_b, x4_s;

  pipelined_rca #(.WIDTH(8), .STAGES(1)) u_w8s1 (
    .clk(clk), .rst(rst), .in_valid(x1_valid), .in_ready(x1_rdy),
    .in_a(x1_a), .in_b(x1_b), .in_cin(1'b0), .in_sub(x1_sub),
    .out_valid(x1_ov), .out_ready(aux_ready), .out_sum(x1_s),
    .out_cout(x1_co), .out_ovf(x1_of)
  );
  pipelined_rca #(.WIDTH(12), .STAGES(3)) u_w12s3 (
    .clk(clk), .rst(rst), .in_valid(x3_valid), .in_ready(x3_rdy),
    .in_a(x3_a), .in_b(x3_b), .in_cin(1'b0), .in_sub(x3_sub),
    .out_valid(x3_ov), .out_ready(aux_ready), .out_sum(x3_s),
    .out_cout(x3_co), .out_ovf(x3_of)
  );
  pipelined_rca #(.WIDTH(4), .STAGES(4)) u_w4s4 (
    .clk(clk), .rst(rst), .in_valid(x4_valid), .in_ready(x4_rdy),
    .in_a(x4_a), .in_b(x4_b), .in_cin(1'b0), .in_sub(x4_sub),
    .out_valid(x4_ov), .out_ready(aux_ready), .out_sum(x4_s),
    .out_cout(x4_co), .out_ovf(x4_of)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs[10];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference: {ovf, cout, sum} from plain integer arithmetic.
  function automatic logic [17:0] ref_op(input logic [15:0] a, input logic [15:0] b,
                                         input logic cin, input logic sub);
    logic [16:0] u;
    int r;
    if (sub) begin
      u = 17'h10000 + {1'b0, a} - {1'b0, b} - {16'b0, cin};
      r = int'($signed(a)) - int'($signed(b)) - int'(cin);
    end else begin
      u = {1'b0, a} + {1'b0, b} + {16'b0, cin};
      r = int'($signed(a)) + int'($signed(b)) + int'(cin);
    end
    return {(r > 32767 || r < -32768), u[16], u[15:0]};
  endfunction

  // Issues one op at posedge+1 and counts cycles until the result appears.
  task automatic run_one(input vec_t v, input string tag);
    int lat;
    in_valid = 1'b1; in_a = v.a; in_b = v.b; in_cin = v.cin; in_sub = v.sub;
    #3;
    check({tag, "_in_ready"}, in_ready, 1);
    cyc();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      cyc();
      lat++;
    end
    check({tag, "_latency"}, lat, 4);
    check({tag, "_sum"}, out_sum, v.sum);
    check({tag, "_cout"}, out_cout, v.cout);
    check({tag, "_ovf"}, out_ovf, v.ovf);
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] expq[$];
    logic [17:0] refq[$];
    vec_t v;
    int nxt, got, irdy_low, first_low, vgap, stale, l1, l3, l4;
    logic started, pending, held;
    logic [17:0] held_val, cur;

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
    out_ready = 1'b1;
    x1_valid = 1'b0; x1_a = '0; x1_b = '0; x1_sub = 1'b0;
    x3_valid = 1'b0; x3_a = '0; x3_b = '0; x3_sub = 1'b0;
    x4_valid = 1'b0; x4_a = '0; x4_b = '0; x4_sub = 1'b0;

    vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[6] = '{16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000C, 1'b1, 1'b0};
    vecs[7] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[8] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[9] = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};

    #3;
    check("reset_out_valid", out_valid, 0);
    check("reset_out_sum", out_sum, 0);
    check("reset_out_cout", out_cout, 0);
    check("reset_out_ovf", out_ovf, 0);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    cyc();
    check("post_reset_in_ready", in_ready, 1);

    for (int i = 0; i < 10; i++) run_one(vecs[i], $sformatf("vec%0d", i));

    // Degenerate shapes: one op each, latency equals the stage count.
    x1_valid = 1'b1; x1_a = 8'hF0;  x1_b = 8'h20;  x1_sub = 1'b0;
    x3_valid = 1'b1; x3_a = 12'h800; x3_b = 12'h001; x3_sub = 1'b1;
    x4_valid = 1'b1; x4_a = 4'h7;   x4_b = 4'h1;   x4_sub = 1'b0;
    l1 = 0; l3 = 0; l4 = 0;
    for (int l = 1; l <= 8; l++) begin
      cyc();
      x1_valid = 1'b0; x3_valid = 1'b0; x4_valid = 1'b0;
      if (x1_ov && l1 == 0) begin
        l1 = l;
        check("w8s1_result", {x1_of, x1_co, x1_s}, {1'b0, 1'b1, 8'h10});
      end
      if (x3_ov && l3 == 0) begin
        l3 = l;
        check("w12s3_result", {x3_of, x3_co, x3_s}, {1'b1, 1'b1, 12'h7FF});
      end
      if (x4_ov && l4 == 0) begin
        l4 = l;
        check("w4s4_result", {x4_of, x4_co, x4_s}, {1'b1, 1'b0, 4'h8});
      end
    end
    check("w8s1_latency", l1, 1);
    check("w12s3_latency", l3, 3);
    check("w4s4_latency", l4, 4);

    // Stream of 10 ops, out_ready low during cycles 6..9.
    nxt = 0; got = 0; irdy_low = 0; first_low = -1; vgap = 0; started = 1'b0;
    for (int t = 0; t < 40 && got < 10; t++) begin
      in_valid = (nxt < 10); in_a = 16'(nxt); in_b = 16'(3 * nxt); in_cin = 1'b0; in_sub = 1'b0;
      out_ready = !(t >= 6 && t <= 9);
      #4;
      if (in_valid && in_ready) begin
        expq.push_back(16'(4 * nxt));
        nxt++;
      end
      if (!in_ready) begin
        irdy_low++;
        if (first_low < 0) first_low = t;
      end
      if (out_valid) started = 1'b1;
      else if (started) vgap++;
      if (out_valid && out_ready) begin
        if (expq.size() == 0) check("stream_extra_result", 1, 0);
        else check($sformatf("stream_sum%0d", got), out_sum, expq.pop_front());
        got++;
      end
      cyc();
    end
    check("stream_results", got, 10);
    check("stream_accepted", nxt, 10);
    check("stream_in_ready_low_cycles", irdy_low, 4);
    check("stream_in_ready_first_low", first_low, 6);
    check("stream_out_gaps", vgap, 0);

    in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) cyc();

    // Bubble collapse: op, 2 idle, op, output stalled.
    out_ready = 1'b0; irdy_low = 0;
    for (int t = 0; t < 10; t++) begin
      in_valid = (t == 0 || t == 3);
      in_a = (t == 0) ? 16'h0101 : 16'h1000;
      in_b = (t == 0) ? 16'h0202 : 16'h0001;
      #3;
      if (!in_ready) irdy_low++;
      cyc();
    end
    in_valid = 1'b0;
    check("bubble_in_ready_low", irdy_low, 0);
    check("bubble_first", {out_valid, out_sum}, {1'b1, 16'h0303});
    out_ready = 1'b1;
    cyc();
    check("bubble_second_adjacent", {out_valid, out_sum}, {1'b1, 16'h1001});
    cyc();
    check("bubble_drained", out_valid, 0);

    // Async reset with ops in flight.
    for (int t = 0; t < 3; t++) begin
      in_valid = 1'b1; in_a = 16'(t + 1); in_b = 16'h0100;
      cyc();
    end
    in_valid = 1'b0;
    cyc();
    check("midreset_pre_valid", out_valid, 1);
    #1 rst = 1'b1;
    #1;
    check("midreset_out_valid", out_valid, 0);
    check("midreset_out_sum", out_sum, 0);
    @(posedge clk);
    #3 rst = 1'b0;
    stale = 0;
    for (int t = 0; t < 8; t++) begin
      cyc();
      if (out_valid) stale++;
    end
    check("midreset_stale_results", stale, 0);
    v = '{16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0};
    run_one(v, "midreset_fresh");

    // Random valid/ready against the integer model, with hold-stability checks.
    pending = 1'b0; held = 1'b0; held_val = '0;
    for (int t = 0; t < 400; t++) begin
      if (!pending) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_a = 16'($urandom); in_b = 16'($urandom);
        in_cin = 1'($urandom); in_sub = 1'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #4;
      cur = {out_ovf, out_cout, out_sum};
      if (held) check("rand_hold_stable", {out_valid, cur}, {1'b1, held_val});
      held = out_valid && !out_ready;
      held_val = cur;
      pending = in_valid && !in_ready;
      if (in_valid && in_ready) refq.push_back(ref_op(in_a, in_b, in_cin, in_sub));
      if (out_valid && out_ready) begin
        if (refq.size() == 0) check("rand_extra_result", 1, 0);
        else check("rand_result", cur, refq.pop_front());
      end
      cyc();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int t = 0; t < 20 && refq.size() > 0; t++) begin
      #4;
      if (out_valid) check("rand_drain_result", {out_ovf, out_cout, out_sum}, refq.pop_front());
      cyc();
    end
    check("rand_all_returned", refq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
